// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared command/target encodings, header layout and decoder states.
// The CHK state only exists when CMD_FRAME_CHK_EN is defined.
package ctrl_pkg;
    localparam logic [1:0] CMD_KEY  = 2'b00;
    localparam logic [1:0] CMD_TEXT = 2'b01;
    localparam logic [1:0] CMD_DEST = 2'b10;
    localparam logic [1:0] CMD_HASH = 2'b11;
    localparam logic [1:0] TGT_AES  = 2'd0;
    localparam logic [1:0] TGT_SHA  = 2'd1;
    localparam logic [1:0] TGT_MEM  = 2'd2;
    localparam int HDR_CMD_HI = 7;
    localparam int HDR_CMD_LO = 6;
    localparam int HDR_TGT_HI = 5;
    localparam int HDR_TGT_LO = 4;
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
`ifdef CMD_FRAME_CHK_EN
        S_CHK,
`endif
        S_DROP,
        S_HOLD
    } state_t;
endpackage

// File: rtl/frame_timeout_ctr.sv
// frame_timeout_ctr: idle-cycle counter with clear/enable; expired is high while the count sits at MAX.
module frame_timeout_ctr #(
    parameter int MAX = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = (MAX < 2) ? 1 : $clog2(MAX + 1);
    localparam logic [W-1:0] LIM = W'(MAX);
    logic [W-1:0] cnt;
    assign expired = (MAX != 0) && en && (cnt == LIM);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !expired && MAX != 0)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/cmd_bus_decoder.sv
// cmd_bus_decoder: reassembles header + address byte frames into one transaction with one-hot ack.
// CMD_FRAME_CHK_EN adds a trailing XOR check byte per frame.
module cmd_bus_decoder
    import ctrl_pkg::*;
#(
    parameter int ADDRW   = 24,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       data_bus_in,
    input  logic             data_bus_valid,
    output logic             bus_ready,
    output logic             txn_valid,
    input  logic             txn_ready,
    output logic [1:0]       txn_cmd,
    output logic [1:0]       txn_target,
    output logic [ADDRW-1:0] txn_addr,
    output logic [2:0]       ack_out,
    output logic             err
);
    localparam int ABYTES = ADDRW / 8;
`ifdef CMD_FRAME_CHK_EN
    localparam int DROPN = ABYTES + 1;
    localparam state_t ADDR_DONE = S_CHK;
`else
    localparam int DROPN = ABYTES;
    localparam state_t ADDR_DONE = S_HOLD;
`endif
    localparam int CW = $clog2(DROPN + 1);
    state_t state, nxt;
    logic [CW-1:0] cnt;
    logic acc, active, expired, err_n;
`ifdef CMD_FRAME_CHK_EN
    logic [7:0] chk;
`endif
    assign bus_ready = state != S_HOLD;
    assign txn_valid = state == S_HOLD;
    assign active    = state != S_IDLE && state != S_HOLD;
    // a byte landing in the cycle the timeout fires is not taken
    assign acc       = data_bus_valid && bus_ready && !expired;
    frame_timeout_ctr #(.MAX(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (acc || !active),
        .en      (active),
        .expired (expired)
    );
    always_comb begin
        nxt   = state;
        err_n = 1'b0;
        if (expired) begin
            nxt   = S_IDLE;
            err_n = 1'b1;
        end else begin
            case (state)
                S_IDLE: if (acc) nxt = (data_bus_in[HDR_TGT_HI:HDR_TGT_LO] == 2'd3) ? S_DROP : S_ADDR;
                S_ADDR: if (acc && cnt == CW'(ABYTES - 1)) nxt = ADDR_DONE;
`ifdef CMD_FRAME_CHK_EN
                S_CHK: if (acc) begin
                    nxt   = (data_bus_in == chk) ? S_HOLD : S_IDLE;
                    err_n = data_bus_in != chk;
                end
`endif
                S_DROP: if (acc && cnt == CW'(DROPN - 1)) begin
                    nxt   = S_IDLE;
                    err_n = 1'b1;
                end
                S_HOLD: if (txn_ready) nxt = S_IDLE;
                default: nxt = S_IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            txn_cmd    <= '0;
            txn_target <= '0;
            txn_addr   <= '0;
            ack_out    <= '0;
            err        <= 1'b0;
            cnt        <= '0;
`ifdef CMD_FRAME_CHK_EN
            chk        <= '0;
`endif
        end else begin
            state   <= nxt;
            err     <= err_n;
            ack_out <= (txn_valid && txn_ready) ?
                       {txn_target == TGT_MEM, txn_target == TGT_SHA, txn_target == TGT_AES} : 3'b000;
            if (acc) begin
                cnt <= (state == S_IDLE) ? '0 : cnt + 1'b1;
                if (state == S_IDLE) begin
                    txn_cmd    <= data_bus_in[HDR_CMD_HI:HDR_CMD_LO];
                    txn_target <= data_bus_in[HDR_TGT_HI:HDR_TGT_LO];
                end
                if (state == S_ADDR)
                    txn_addr <= ADDRW'({txn_addr, data_bus_in});
`ifdef CMD_FRAME_CHK_EN
                chk <= (state == S_IDLE) ? data_bus_in : chk ^ data_bus_in;
`endif
            end
        end
    end
endmodule
